// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter and the packet-locking mux.
package rr_pkg;

    // Source count the arbiter and the mux are built for by default.
    localparam int REQ_NUM_DEF = 7;

    // Packet-lock FSM: waiting for a grant, or streaming the owner's packet.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Encode a one-hot (or zero) vector of up to 32 bits into its bit index.
    // An OR-reduction encoder is enough because at most one bit is set.
    function automatic int unsigned onehot2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_out_slice.sv
// Single output register slice with valid/ready handshake and same-cycle
// reload, so a full slice that is being drained can accept the next beat.
module rr_out_slice #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [IDX_W-1:0]  in_src,
    input  logic              out_ready,
    output logic              slot_free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_src
);

    // The slot can take a beat when it is empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;

    // Register the beat on load; drop valid only when drained without reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload is an ordinary register (not a memory array),
            // so it is reset along with valid to give a fully defined reset state.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_src   <= in_src;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_pkt_mux.sv
// Packet-locking mux behind the rr_arb round-robin arbiter. Requests are
// shown to the arbiter only while idle; the granted source then owns the
// output until its last beat or the MAX_BEATS cap, so the arbiter pointer
// advances once per packet.
module rr_pkt_mux
    import rr_pkg::*;
#(
    parameter  int REQ_NUM   = REQ_NUM_DEF,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 16,
    localparam int IDX_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_NUM-1:0]          src_valid,
    input  logic [REQ_NUM*DATA_W-1:0]   src_data,
    input  logic [REQ_NUM-1:0]          src_last,
    output logic [REQ_NUM-1:0]          src_ready,
    output logic [REQ_NUM-1:0]          arb_req,
    input  logic [REQ_NUM-1:0]          arb_grant,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [IDX_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic                        err_trunc
);

    // Beat count at which the current beat is forced to close the packet.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_e              state;
    state_e              state_nxt;
    logic [REQ_NUM-1:0]  owner_oh;
    logic [IDX_W-1:0]    owner_idx;
    logic [CNT_W-1:0]    beat_cnt;

    logic                slot_free;
    logic                own_valid;
    logic                own_last;
    logic [DATA_W-1:0]   own_data;
    logic                beat_acc;
    logic                beat_last;

    // Owner's handshake bits, selected through the latched one-hot mask.
    assign own_valid = |(src_valid & owner_oh);
    assign own_last  = |(src_last  & owner_oh);

    // AND-OR mux of the owner's payload; owner_oh has at most one bit set.
    always_comb begin
        own_data = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (owner_oh[i]) begin
                own_data = own_data | src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A beat moves only while locked, the owner is valid and the slot is free.
    assign beat_acc  = (state == BUSY) && own_valid && slot_free;
    assign beat_last = own_last || (beat_cnt == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbiter request and per-source ready.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_nxt = state;
        arb_req   = '0;
        src_ready = '0;
        case (state)
            IDLE: begin
                arb_req = src_valid;
                if (|arb_grant) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // arb_req stays 0 here, which freezes the arbiter pointer.
                src_ready = owner_oh & {REQ_NUM{slot_free}};
                if (beat_acc && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Owner latch, beat counter and the truncation pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_oh  <= '0;
            owner_idx <= '0;
            beat_cnt  <= '0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= beat_acc && beat_last && !own_last;
            if (state == IDLE && |arb_grant) begin
                owner_oh  <= arb_grant;
                owner_idx <= IDX_W'(onehot2idx(32'(arb_grant)));
                beat_cnt  <= '0;
            end else if (beat_acc) begin
                beat_cnt  <= beat_cnt + 1'b1;
            end
        end
    end

    rr_out_slice #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .load      (beat_acc),
        .in_data   (own_data),
        .in_last   (beat_last),
        .in_src    (owner_idx),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Directed bench for rr_pkt_mux with a small round-robin arbiter model and
// scripted per-source packet generators; expectations are hand-computed.
module tb_rr_pkt_mux;

    localparam int REQ_NUM   = 7;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 4;
    localparam int IDX_W     = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [REQ_NUM-1:0]        src_valid;
    logic [REQ_NUM*DATA_W-1:0] src_data;
    logic [REQ_NUM-1:0]        src_last;
    logic [REQ_NUM-1:0]        src_ready;
    logic [REQ_NUM-1:0]        arb_req;
    logic [REQ_NUM-1:0]        arb_grant;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [IDX_W-1:0]          out_src;
    logic                      out_ready;
    logic                      err_trunc;

    rr_pkt_mux #(
        .REQ_NUM   (REQ_NUM),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    // Round-robin arbiter model: first requester at or after ptr wins.
    logic [2:0] ptr;
    always_comb begin
        int j;
        arb_grant = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            j = (int'(ptr) + k) % REQ_NUM;
            if (arb_grant == '0 && arb_req[j]) arb_grant[j] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst) ptr <= '0;
        else begin
            for (int k = 0; k < REQ_NUM; k++)
                if (arb_grant[k]) ptr <= 3'((k + 1) % REQ_NUM);
        end
    end

    // Per-source packet scripts.
    int left [REQ_NUM];   // beats still to send
    int plen [REQ_NUM];   // packet length, 0 = never assert last
    int pos  [REQ_NUM];   // position within current packet
    int seq  [REQ_NUM];   // running beat number, forms the payload
    bit stall[REQ_NUM];

    logic [35:0] obs[$];  // {last, src, data} of every drained beat
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int err_cnt = 0;

    function automatic logic [35:0] pk(input logic l, input logic [2:0] s, input logic [31:0] d);
        return {l, s, d};
    endfunction

    function automatic logic [35:0] obs_at(input int i);
        return (i < obs.size()) ? obs[i] : '1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < REQ_NUM; i++) begin
            src_valid[i] = (left[i] > 0) && !stall[i];
            src_data[i*DATA_W +: DATA_W] = 32'(i * 256) + 32'(seq[i]);
            src_last[i] = (plen[i] != 0) && (pos[i] == plen[i] - 1);
        end
    endtask

    task automatic set_src(input int i, input int nbeats, input int len);
        left[i] = nbeats;
        plen[i] = len;
        pos[i]  = 0;
        seq[i]  = 0;
    endtask

    // One clock: log drained beats, advance accepted sources, re-drive.
    task automatic tick();
        logic [REQ_NUM-1:0] acc;
        acc = rst ? '0 : (src_valid & src_ready);
        if (out_valid && out_ready && !rst) obs.push_back({out_last, out_src, out_data});
        @(posedge clk);
        #1;
        if (err_trunc) err_cnt++;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (acc[i]) begin
                left[i]--;
                seq[i]++;
                pos[i] = (plen[i] != 0 && pos[i] == plen[i] - 1) ? 0 : pos[i] + 1;
            end
        end
        drive();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < REQ_NUM; i++) begin
            set_src(i, 0, 0);
            stall[i] = 1'b0;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        obs.delete();
        err_cnt = 0;
    endtask

    logic [35:0] exp2 [12];

    initial begin
        // ---- Reset state ----
        reset_dut();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_trunc", err_trunc, 0);
        check("rst_arb_req", arb_req, 0);
        check("rst_src_ready", src_ready, 0);

        // ---- Single source: src2, two 3-beat packets ----
        set_src(2, 6, 3);
        drive();
        #1;
        check("s1_idle_req", arb_req, 7'b0000100);
        check("s1_idle_ready", src_ready, 0);
        tick();
        check("s1_busy_req", arb_req, 0);
        check("s1_busy_ready", src_ready, 7'b0000100);
        check("s1_no_out_yet", out_valid, 0);
        tick();
        check("s1_d0", pk(out_last, out_src, out_data), pk(0, 2, 'h200));
        check("s1_d0_valid", out_valid, 1);
        tick();
        check("s1_d1", pk(out_last, out_src, out_data), pk(0, 2, 'h201));
        tick();
        check("s1_d2", pk(out_last, out_src, out_data), pk(1, 2, 'h202));
        check("s1_gap_req", arb_req, 7'b0000100);
        check("s1_gap_ready", src_ready, 0);
        tick();
        check("s1_bubble", out_valid, 0);
        tick();
        check("s1_d3", pk(out_last, out_src, out_data), pk(0, 2, 'h203));
        tick();
        tick();
        check("s1_d5", pk(out_last, out_src, out_data), pk(1, 2, 'h205));

        // ---- Round-robin fairness: sources 0,3,6 with 2-beat packets ----
        reset_dut();
        set_src(0, 4, 2);
        set_src(3, 4, 2);
        set_src(6, 4, 2);
        drive();
        #1;
        exp2 = '{pk(0, 0, 'h000), pk(1, 0, 'h001), pk(0, 3, 'h300), pk(1, 3, 'h301),
                 pk(0, 6, 'h600), pk(1, 6, 'h601), pk(0, 0, 'h002), pk(1, 0, 'h003),
                 pk(0, 3, 'h302), pk(1, 3, 'h303), pk(0, 6, 'h602), pk(1, 6, 'h603)};
        for (int c = 0; c < 60 && obs.size() < 12; c++) tick();
        check("rr_count", obs.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("rr_beat%0d", i), obs_at(i), exp2[i]);

        // ---- Backpressure: out_ready low for 4 cycles after first beat ----
        reset_dut();
        set_src(5, 3, 3);
        drive();
        #1;
        tick();
        tick();
        check("bp_d0", out_data, 'h500);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_ready%0d", c), src_ready, 0);
            check($sformatf("bp_hold%0d", c), pk(out_last, out_src, out_data), pk(0, 5, 'h500));
            check($sformatf("bp_valid%0d", c), out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", src_ready, 7'b0100000);
        for (int c = 0; c < 12 && obs.size() < 3; c++) tick();
        tick();
        tick();
        check("bp_count", obs.size(), 3);
        check("bp_beat0", obs_at(0), pk(0, 5, 'h500));
        check("bp_beat1", obs_at(1), pk(0, 5, 'h501));
        check("bp_beat2", obs_at(2), pk(1, 5, 'h502));

        // ---- Truncation: src1 sends 6 beats, no last, cap is 4 ----
        reset_dut();
        set_src(1, 6, 0);
        drive();
        #1;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (out_valid && out_last) check("tr_pulse_align", err_trunc, 1);
        end
        check("tr_count", obs.size(), 6);
        check("tr_beat0", obs_at(0), pk(0, 1, 'h100));
        check("tr_beat2", obs_at(2), pk(0, 1, 'h102));
        check("tr_beat3", obs_at(3), pk(1, 1, 'h103));
        check("tr_beat4", obs_at(4), pk(0, 1, 'h104));
        check("tr_beat5", obs_at(5), pk(0, 1, 'h105));
        check("tr_err_pulses", err_cnt, 1);

        // ---- Owner stall: src2 owner pauses 3 cycles while src4 waits ----
        reset_dut();
        set_src(2, 4, 4);
        set_src(4, 1, 1);
        drive();
        #1;
        tick();
        tick();
        tick();
        stall[2] = 1'b1;
        drive();
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("st_ready%0d", c), src_ready, 7'b0000100);
            check($sformatf("st_req%0d", c), arb_req, 0);
            tick();
        end
        stall[2] = 1'b0;
        drive();
        #1;
        for (int c = 0; c < 20 && obs.size() < 5; c++) tick();
        check("st_count", obs.size(), 5);
        check("st_beat1", obs_at(1), pk(0, 2, 'h201));
        check("st_beat2", obs_at(2), pk(0, 2, 'h202));
        check("st_beat3", obs_at(3), pk(1, 2, 'h203));
        check("st_beat4", obs_at(4), pk(1, 4, 'h400));
        check("st_no_err", err_cnt, 0);

        // ---- Reset mid-packet: src3, reset during beat 2 ----
        reset_dut();
        set_src(3, 3, 3);
        drive();
        #1;
        tick();
        tick();
        tick();
        check("mr_d1", out_data, 'h301);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 0);
        check("mr_out_src", out_src, 0);
        check("mr_out_last", out_last, 0);
        check("mr_err_trunc", err_trunc, 0);
        check("mr_src_ready", src_ready, 0);
        check("mr_rearb_req", arb_req, 7'b0001000);
        tick();
        tick();
        check("mr_after", pk(out_last, out_src, out_data), pk(1, 3, 'h302));
        tick();
        check("mr_no_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
